module_sim_ctrl: RTL

Memory-mapped test-control peripheral on the CPU data bus. It is the device side of the pass/fail handshake: test software writes a riscv-tests style `tohost` value, and the block decodes it into sticky pass/fail/timeout status and a test number. It also provides a free-running cycle counter, a timeout watchdog, a scratch register and a byte console port. `module_top` instantiates it behind the address decoder, and the simulation harness watches only `done`, `pass`, `fail` and `timeout`.

---
 rtl/module_sim_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/module_sim_ctrl.sv
// rtl/module_sim_ctrl.sv - memory-mapped test-control peripheral (tohost pass/fail, cycle counter, watchdog, scratch, console)
//
// Purpose:
//   Device side of the riscv-tests tohost handshake. Test software writes a
//   tohost value and the block decodes it into sticky PASS/FAIL status plus a
//   test number. A free-running cycle counter drives a watchdog that forces
//   TIMEOUT if the test never reports. Also provides a scratch register and a
//   byte console output.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   sel        - chip select; qualifies we/addr
//   we         - 1 = write, 0 = read
//   addr[1:0]  - word offset: 0 TOHOST, 1 CYCLE, 2 SCRATCH, 3 CONSOLE/STATUS
//   wdata[31:0]- write data
//   rdata[31:0]- registered read data, holds when no read is issued
//   done       - state is not RUN
//   pass       - state is PASS
//   fail       - state is FAIL
//   timeout    - state is TIMEOUT
//   testnum    - tohost[31:1] of the last accepted TOHOST write
//   char_valid - one-cycle pulse per CONSOLE write
//   char_data  - last console byte written

module module_sim_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] testnum,
    output logic        char_valid,
    output logic [7:0]  char_data
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] COUNT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] A_TOHOST  = 2'd0;
    localparam logic [1:0] A_CYCLE   = 2'd1;
    localparam logic [1:0] A_SCRATCH = 2'd2;
    localparam logic [1:0] A_CONSOLE = 2'd3;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] counter_q;
    logic [31:0] tohost_q;
    logic [31:0] scratch_q;

    logic        bus_wr;
    logic        bus_rd;
    logic        tohost_acc;
    logic        console_wr;
    logic [31:0] rd_mux;

    assign bus_wr     = sel & we;
    assign bus_rd     = sel & ~we;
    // Only odd tohost values are reports; even values are ignored entirely.
    assign tohost_acc = bus_wr && (addr == A_TOHOST) && (state_q == ST_RUN) && wdata[0];
    assign console_wr = bus_wr && (addr == A_CONSOLE);

    // Next-state logic. An accepted tohost write takes priority over the
    // watchdog expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (tohost_acc) begin
                state_d = (wdata == 32'd1) ? ST_PASS : ST_FAIL;
            end else if (counter_q == COUNT_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            A_TOHOST:  rd_mux = tohost_q;
            A_CYCLE:   rd_mux = counter_q;
            A_SCRATCH: rd_mux = scratch_q;
            A_CONSOLE: rd_mux = {30'd0, state_q};
            default:   rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            counter_q  <= 32'd0;
            tohost_q   <= 32'd0;
            scratch_q  <= 32'd0;
            rdata      <= 32'd0;
            char_valid <= 1'b0;
            char_data  <= 8'd0;
        end else begin
            state_q <= state_d;
            // Counting only while staying in RUN freezes the counter on the
            // very edge that enters a terminal state (TIMEOUT leaves it at
            // TIMEOUT_CYCLES-1).
            if (state_d == ST_RUN) begin
                counter_q <= counter_q + 32'd1;
            end
            if (tohost_acc) begin
                tohost_q <= wdata;
            end
            if (bus_wr && (addr == A_SCRATCH)) begin
                scratch_q <= wdata;
            end
            char_valid <= console_wr;
            if (console_wr) begin
                char_data <= wdata[7:0];
            end
            if (bus_rd) begin
                rdata <= rd_mux;
            end
        end
    end

    assign done    = (state_q != ST_RUN);
    assign pass    = (state_q == ST_PASS);
    assign fail    = (state_q == ST_FAIL);
    assign timeout = (state_q == ST_TIMEOUT);
    assign testnum = tohost_q[31:1];

endmodule
